// File: rtl/clock_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// The RTL and the testbench model both use these clamp rules.
package clock_div_pkg;

    localparam int unsigned MIN_DIV = 2;

    // High time loaded at reset for a given divisor.
    function automatic int unsigned reset_high(input int unsigned div);
        return div >> 1;
    endfunction

    function automatic int unsigned clamp_div(input int unsigned div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

    // div must already be clamped, so div-1 is at least 1.
    function automatic int unsigned clamp_high(input int unsigned div, input int unsigned high);
        if (high == 0) begin
            return 1;
        end
        if (high > div - 1) begin
            return div - 1;
        end
        return high;
    endfunction

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: period counter, active and shadow settings, and
// registered clk_div/tick outputs. New settings swap in only at a period boundary.
module clock_div_chan
    import clock_div_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_DIV = 3
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_div,
    input  logic [WIDTH-1:0] load_high,
    output logic             clk_div,
    output logic             tick,
    output logic             pending
);

    localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(RESET_DIV);
    localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(reset_high(RESET_DIV));

    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] div_reg, div_next;
    logic [WIDTH-1:0] high_reg, high_next;
    logic [WIDTH-1:0] sh_div_reg, sh_div_next;
    logic [WIDTH-1:0] sh_high_reg, sh_high_next;
    logic             pending_reg, pending_next;
    logic             clk_div_reg, clk_div_next;
    logic             tick_reg, tick_next;
    logic             wrap;
    logic             apply;

    always_comb begin
        cnt_next     = cnt_reg;
        div_next     = div_reg;
        high_next    = high_reg;
        sh_div_next  = sh_div_reg;
        sh_high_next = sh_high_reg;
        pending_next = pending_reg;
        clk_div_next = 1'b0;
        tick_next    = 1'b0;
        wrap         = (cnt_reg == div_reg - WIDTH'(1));
        apply        = 1'b0;

        if (en) begin
            clk_div_next = (cnt_reg < high_reg);
            tick_next    = (cnt_reg == '0);
            cnt_next     = wrap ? '0 : cnt_reg + WIDTH'(1);
            apply        = wrap && pending_reg;
        end else begin
            // A stopped channel has no period to finish, so settle the shadow now.
            cnt_next = '0;
            apply    = pending_reg;
        end

        if (apply) begin
            div_next     = sh_div_reg;
            high_next    = sh_high_reg;
            pending_next = 1'b0;
        end

        // load is only granted while pending is clear, so it never races apply.
        if (load) begin
            sh_div_next  = load_div;
            sh_high_next = load_high;
            pending_next = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_reg     <= '0;
            div_reg     <= RST_DIV;
            high_reg    <= RST_HIGH;
            sh_div_reg  <= RST_DIV;
            sh_high_reg <= RST_HIGH;
            pending_reg <= 1'b0;
            clk_div_reg <= 1'b0;
            tick_reg    <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            div_reg     <= div_next;
            high_reg    <= high_next;
            sh_div_reg  <= sh_div_next;
            sh_high_reg <= sh_high_next;
            pending_reg <= pending_next;
            clk_div_reg <= clk_div_next;
            tick_reg    <= tick_next;
        end
    end

    assign clk_div = clk_div_reg;
    assign tick    = tick_reg;
    assign pending = pending_reg;

endmodule

// File: rtl/clock_div_prog.sv
// Multi-channel programmable integer clock divider with a valid/ready
// configuration port; clamps requests once and routes them to one channel.
module clock_div_prog
    import clock_div_pkg::*;
#(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_DIV = 3
) (
    input  logic                                                clk_in,
    input  logic                                                rst,
    input  logic [CHANNELS-1:0]                                 en,
    input  logic                                                cfg_valid,
    output logic                                                cfg_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
    input  logic [WIDTH-1:0]                                    cfg_div,
    input  logic [WIDTH-1:0]                                    cfg_high,
    output logic [CHANNELS-1:0]                                 clk_div,
    output logic [CHANNELS-1:0]                                 tick,
    output logic [CHANNELS-1:0]                                 pending
);

    localparam int CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CHAN_SLOTS = 1 << CHAN_W;

    logic [WIDTH-1:0]      div_clamped;
    logic [WIDTH-1:0]      high_clamped;
    logic [CHAN_SLOTS-1:0] pending_ext;
    logic                  accept;
    logic [CHANNELS-1:0]   load;

    always_comb begin
        div_clamped  = WIDTH'(clamp_div(32'(cfg_div)));
        high_clamped = WIDTH'(clamp_high(32'(div_clamped), 32'(cfg_high)));
    end

    // Unused channel slots read as not pending, so out-of-range requests
    // are always accepted and then simply match no channel.
    assign pending_ext = CHAN_SLOTS'(pending);
    assign cfg_ready   = ~pending_ext[cfg_chan];
    assign accept      = cfg_valid & cfg_ready;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign load[gi] = accept && (cfg_chan == CHAN_W'(gi));

            clock_div_chan #(
                .WIDTH     (WIDTH),
                .RESET_DIV (RESET_DIV)
            ) u_chan (
                .clk_in    (clk_in),
                .rst       (rst),
                .en        (en[gi]),
                .load      (load[gi]),
                .load_div  (div_clamped),
                .load_high (high_clamped),
                .clk_div   (clk_div[gi]),
                .tick      (tick[gi]),
                .pending   (pending[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clock_div_prog.sv
// Directed, table-driven bench for clock_div_prog: a two-channel default
// instance plus a three-channel instance for out-of-range channel requests.
module tb_clock_div_prog;
    import clock_div_pkg::*;

    logic       clk_in = 1'b0;
    logic       rst;
    logic [1:0] en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [0:0] cfg_chan;
    logic [7:0] cfg_div;
    logic [7:0] cfg_high;
    logic [1:0] clk_div;
    logic [1:0] tick;
    logic [1:0] pending;

    logic [2:0] en3;
    logic       cfg_valid3;
    logic       cfg_ready3;
    logic [1:0] cfg_chan3;
    logic [7:0] cfg_div3;
    logic [7:0] cfg_high3;
    logic [2:0] clk_div3;
    logic [2:0] tick3;
    logic [2:0] pending3;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    clock_div_prog u_dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .clk_div   (clk_div),
        .tick      (tick),
        .pending   (pending)
    );

    clock_div_prog #(.CHANNELS(3), .WIDTH(8), .RESET_DIV(3)) u_dut3 (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en3),
        .cfg_valid (cfg_valid3),
        .cfg_ready (cfg_ready3),
        .cfg_chan  (cfg_chan3),
        .cfg_div   (cfg_div3),
        .cfg_high  (cfg_high3),
        .clk_div   (clk_div3),
        .tick      (tick3),
        .pending   (pending3)
    );

    typedef struct {
        logic [1:0] en;
        logic       valid;
        logic       chan;
        logic [7:0] div;
        logic [7:0] high;
        logic       rdy;
        logic [1:0] clk;
        logic [1:0] tck;
        logic [1:0] pend;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] e, input logic v, input logic c,
                       input logic [7:0] d, input logic [7:0] h, input logic r,
                       input logic [1:0] ck, input logic [1:0] tk, input logic [1:0] pd);
        vec_t x;
        x.en = e; x.valid = v; x.chan = c; x.div = d; x.high = h;
        x.rdy = r; x.clk = ck; x.tck = tk; x.pend = pd;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        // en, valid, chan, div, high | ready, clk_div, tick, pending
        add(2'b11, 0, 0, 0, 0, 1, 2'b11, 2'b11, 2'b00);
        add(2'b11, 1, 0, 5, 2, 1, 2'b00, 2'b00, 2'b01); // accept at cnt=1
        add(2'b11, 1, 0, 4, 9, 0, 2'b00, 2'b00, 2'b00); // refused, wrap applies 5/2
        add(2'b11, 1, 0, 4, 9, 1, 2'b11, 2'b11, 2'b01); // retry accepted
        add(2'b11, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01);
        add(2'b11, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01);
        add(2'b11, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01);
        add(2'b11, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00); // wrap applies 4/3
        add(2'b11, 0, 0, 0, 0, 1, 2'b01, 2'b01, 2'b00);
        add(2'b11, 0, 0, 0, 0, 1, 2'b11, 2'b10, 2'b00);
        add(2'b11, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00);
        add(2'b11, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00);
        add(2'b11, 1, 0, 1, 0, 1, 2'b11, 2'b11, 2'b01); // clamps to 2/1
        add(2'b11, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01);
        add(2'b11, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01);
        add(2'b11, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00);
        add(2'b11, 0, 0, 0, 0, 1, 2'b01, 2'b01, 2'b00);
        add(2'b11, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00);
        add(2'b11, 0, 0, 0, 0, 1, 2'b11, 2'b11, 2'b00);
        add(2'b11, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00);
        add(2'b01, 1, 1, 4, 2, 1, 2'b01, 2'b01, 2'b10); // ch1 disabled
        add(2'b01, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00); // applied immediately
        add(2'b11, 0, 1, 0, 0, 1, 2'b11, 2'b11, 2'b00);
        add(2'b11, 0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b00);
        add(2'b11, 0, 1, 0, 0, 1, 2'b01, 2'b01, 2'b00);
        add(2'b11, 0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00);
        add(2'b11, 0, 1, 0, 0, 1, 2'b11, 2'b11, 2'b00);
        add(2'b11, 1, 0, 6, 3, 1, 2'b10, 2'b00, 2'b01); // accept on ch0 wrap edge
        add(2'b11, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b01); // still old 2/1 period

        rst = 1'b1; en = '0; cfg_valid = 0; cfg_chan = '0; cfg_div = '0; cfg_high = '0;
        en3 = '0; cfg_valid3 = 0; cfg_chan3 = '0; cfg_div3 = '0; cfg_high3 = '0;

        chk("clamp_div(1)", clamp_div(1), 2);
        chk("clamp_high(4,9)", clamp_high(4, 9), 3);
        chk("clamp_high(2,0)", clamp_high(2, 0), 1);

        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;
        #1;
        chk("reset clk_div", 32'(clk_div), 0);
        chk("reset tick", 32'(tick), 0);
        chk("reset pending", 32'(pending), 0);
        chk("reset ready", 32'(cfg_ready), 1);
        $display("reset released: clk_div=%b tick=%b pending=%b", clk_div, tick, pending);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_in);
            en = vecs[i].en; cfg_valid = vecs[i].valid; cfg_chan = vecs[i].chan;
            cfg_div = vecs[i].div; cfg_high = vecs[i].high;
            #1;
            chk($sformatf("v%0d ready", i), 32'(cfg_ready), 32'(vecs[i].rdy));
            step();
            chk($sformatf("v%0d clk_div", i), 32'(clk_div), 32'(vecs[i].clk));
            chk($sformatf("v%0d tick", i), 32'(tick), 32'(vecs[i].tck));
            chk($sformatf("v%0d pending", i), 32'(pending), 32'(vecs[i].pend));
            $display("vec %0d en=%b cfg=%b/%0d/%0d/%0d clk_div=%b tick=%b pending=%b",
                     i, en, cfg_valid, cfg_chan, cfg_div, cfg_high, clk_div, tick, pending);
        end

        // One-cycle reset with ch0 holding a pending 6/3 request.
        @(negedge clk_in);
        cfg_valid = 0; rst = 1'b1;
        step();
        chk("rst clk_div", 32'(clk_div), 0);
        chk("rst tick", 32'(tick), 0);
        chk("rst pending", 32'(pending), 0);
        $display("mid-run reset: clk_div=%b tick=%b pending=%b", clk_div, tick, pending);
        @(negedge clk_in);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            logic [1:0] exp_v;
            exp_v = (k % 3 == 0) ? 2'b11 : 2'b00;
            step();
            chk($sformatf("post-rst %0d clk_div", k), 32'(clk_div), 32'(exp_v));
            chk($sformatf("post-rst %0d tick", k), 32'(tick), 32'(exp_v));
            $display("post-rst %0d clk_div=%b tick=%b", k, clk_div, tick);
        end

        // Out-of-range channel on the three-channel instance.
        @(negedge clk_in);
        en3 = 3'b111;
        step();
        chk("ch3 start clk_div", 32'(clk_div3), 32'h7);
        chk("ch3 start tick", 32'(tick3), 32'h7);
        @(negedge clk_in);
        cfg_valid3 = 1; cfg_chan3 = 2'd3; cfg_div3 = 8'd5; cfg_high3 = 8'd2;
        #1;
        chk("oor ready", 32'(cfg_ready3), 1);
        step();
        chk("oor pending", 32'(pending3), 0);
        chk("oor clk_div", 32'(clk_div3), 0);
        $display("oor request chan=3: pending=%b clk_div=%b", pending3, clk_div3);
        @(negedge clk_in);
        cfg_valid3 = 0;
        for (int k = 0; k < 5; k++) begin
            logic [2:0] exp3;
            exp3 = (k % 3 == 1) ? 3'b111 : 3'b000;
            step();
            chk($sformatf("oor run %0d clk_div", k), 32'(clk_div3), 32'(exp3));
            chk($sformatf("oor run %0d pending", k), 32'(pending3), 0);
            $display("oor run %0d clk_div=%b pending=%b", k, clk_div3, pending3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
